// File: rtl/cva6_tlb_plru_model_if.sv
`default_nettype none
// ============================================================================
// Module   : cva6_tlb_plru_model_if
// Brief    : Lookup / update / flush bus and state-observation signals for
//            the parametrised Sv32 TLB model with tree pseudo-LRU.
// Revision : 1.0 - initial release
// ============================================================================
interface cva6_tlb_plru_model_if #(
    parameter int TLB_ENTRIES = 4,
    parameter int ASID_WIDTH  = 1
) ();
    localparam int TAG_W = 22 + ASID_WIDTH;

    // flush request
    logic                          flush_i;
    logic [ASID_WIDTH-1:0]         asid_to_be_flushed_i;
    logic [31:0]                   vaddr_to_be_flushed_i;
    // entry update
    logic                          update_valid_i;
    logic                          update_is_4M_i;
    logic [19:0]                   update_vpn_i;
    logic [ASID_WIDTH-1:0]         update_asid_i;
    logic [31:0]                   update_content_i;
    // lookup
    logic                          lu_access_i;
    logic [ASID_WIDTH-1:0]         lu_asid_i;
    logic [31:0]                   lu_vaddr_i;
    logic [31:0]                   lu_content_o;
    logic                          lu_hit_o;
    logic                          lu_is_4M_o;
    // exposed state for non-interference checking
    logic [TLB_ENTRIES*TAG_W-1:0]  port_io_tags_q;
    logic [TLB_ENTRIES*32-1:0]     port_io_content_q;
    logic [TLB_ENTRIES-2:0]        port_io_plru_q;
    logic [TLB_ENTRIES-1:0]        port_io_replace_en;

    modport master (
        output flush_i, asid_to_be_flushed_i, vaddr_to_be_flushed_i,
        output update_valid_i, update_is_4M_i, update_vpn_i, update_asid_i, update_content_i,
        output lu_access_i, lu_asid_i, lu_vaddr_i,
        input  lu_content_o, lu_hit_o, lu_is_4M_o,
        input  port_io_tags_q, port_io_content_q, port_io_plru_q, port_io_replace_en
    );

    modport slave (
        input  flush_i, asid_to_be_flushed_i, vaddr_to_be_flushed_i,
        input  update_valid_i, update_is_4M_i, update_vpn_i, update_asid_i, update_content_i,
        input  lu_access_i, lu_asid_i, lu_vaddr_i,
        output lu_content_o, lu_hit_o, lu_is_4M_o,
        output port_io_tags_q, port_io_content_q, port_io_plru_q, port_io_replace_en
    );
endinterface
`default_nettype wire

// File: rtl/cva6_tlb_plru_model.sv
`default_nettype none
// ============================================================================
// Module   : cva6_tlb_plru_model
// Brief    : Fully-associative Sv32 TLB model with tree pseudo-LRU
//            replacement, invalid-first allocation, duplicate overwrite and
//            selective (ASID / vaddr) flush. Lookup is zero-latency.
// Revision : 1.0 - initial release
// ============================================================================
module cva6_tlb_plru_model #(
    parameter int TLB_ENTRIES = 4,
    parameter int ASID_WIDTH  = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    cva6_tlb_plru_model_if.slave      bus
);
    localparam int TAG_W = 22 + ASID_WIDTH;
    localparam int LVLS  = $clog2(TLB_ENTRIES);
    localparam int IDX_W = (LVLS > 0) ? LVLS : 1;
    localparam int C_G_BIT = 5;

    // Entry state, kept as separate fields and packed only for observation
    logic                   r_valid   [TLB_ENTRIES];
    logic                   r_is_4m   [TLB_ENTRIES];
    logic [9:0]             r_vpn1    [TLB_ENTRIES];
    logic [9:0]             r_vpn0    [TLB_ENTRIES];
    logic [ASID_WIDTH-1:0]  r_asid    [TLB_ENTRIES];
    logic [31:0]            r_content [TLB_ENTRIES];
    logic [TLB_ENTRIES-2:0] r_plru;

    logic [TLB_ENTRIES-1:0] w_lu_match;
    logic [TLB_ENTRIES-1:0] w_fl_hit;
    logic [TLB_ENTRIES-1:0] w_dup_match;
    logic                   w_hit_any;
    logic [IDX_W-1:0]       w_hit_idx;
    logic                   w_lu_hit;
    logic [IDX_W-1:0]       w_repl_idx;
    logic                   w_commit;
    logic [TLB_ENTRIES-2:0] w_plru_next;

    wire w_fl_any_asid  = (bus.asid_to_be_flushed_i == '0);
    wire w_fl_any_vaddr = (bus.vaddr_to_be_flushed_i == 32'd0);

    assign w_commit = bus.update_valid_i & ~bus.flush_i;

    // Walk the tree from the root, marking each node to point away from idx
    function automatic logic [TLB_ENTRIES-2:0] plru_touch(
        input logic [TLB_ENTRIES-2:0] tree,
        input logic [IDX_W-1:0]       idx
    );
        logic [TLB_ENTRIES-2:0] t;
        int                     node;
        logic                   dir;
        t    = tree;
        node = 0;
        for (int l = 0; l < LVLS; l++) begin
            dir     = idx[LVLS-1-l];
            t[node] = ~dir;
            node    = 2 * node + (dir ? 2 : 1);
        end
        return t;
    endfunction

    // Per-entry match terms for lookup, flush and duplicate detection
    generate
        for (genvar g = 0; g < TLB_ENTRIES; g++) begin : g_entry
            wire w_global   = r_content[g][C_G_BIT];
            wire w_fl_vaddr = r_valid[g]
                            && (r_vpn1[g] == bus.vaddr_to_be_flushed_i[31:22])
                            && (r_is_4m[g] || (r_vpn0[g] == bus.vaddr_to_be_flushed_i[21:12]));
            wire w_fl_asid  = (r_asid[g] == bus.asid_to_be_flushed_i) && !w_global;

            assign w_lu_match[g] = r_valid[g]
                                 && (r_vpn1[g] == bus.lu_vaddr_i[31:22])
                                 && (r_is_4m[g] || (r_vpn0[g] == bus.lu_vaddr_i[21:12]))
                                 && ((r_asid[g] == bus.lu_asid_i) || w_global);

            assign w_fl_hit[g] = (w_fl_any_vaddr || w_fl_vaddr) && (w_fl_any_asid || w_fl_asid);

            assign w_dup_match[g] = r_valid[g]
                                  && (r_is_4m[g] == bus.update_is_4M_i)
                                  && (r_vpn1[g] == bus.update_vpn_i[19:10])
                                  && (r_is_4m[g] || (r_vpn0[g] == bus.update_vpn_i[9:0]))
                                  && (r_asid[g] == bus.update_asid_i);

            assign bus.port_io_tags_q[g*TAG_W +: TAG_W] =
                {r_valid[g], r_is_4m[g], r_vpn1[g], r_vpn0[g], r_asid[g]};
            assign bus.port_io_content_q[g*32 +: 32] = r_content[g];
        end
    endgenerate

    // Lowest-index matching entry drives the lookup result
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (w_lu_match[i]) begin
                w_hit_any = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    assign w_lu_hit         = bus.lu_access_i & w_hit_any;
    assign bus.lu_hit_o     = w_lu_hit;
    assign bus.lu_content_o = w_lu_hit ? r_content[w_hit_idx] : 32'd0;
    assign bus.lu_is_4M_o   = w_lu_hit ? r_is_4m[w_hit_idx] : 1'b0;

    // Replacement: duplicate overwrite, else lowest invalid, else PLRU victim
    always_comb begin
        logic             dup_any;
        logic [IDX_W-1:0] dup_idx;
        logic             inv_any;
        logic [IDX_W-1:0] inv_idx;
        int               node;
        dup_any = 1'b0;
        dup_idx = '0;
        inv_any = 1'b0;
        inv_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (w_dup_match[i]) begin
                dup_any = 1'b1;
                dup_idx = IDX_W'(i);
            end
            if (!r_valid[i]) begin
                inv_any = 1'b1;
                inv_idx = IDX_W'(i);
            end
        end
        node = 0;
        for (int l = 0; l < LVLS; l++) begin
            node = 2 * node + (r_plru[node] ? 2 : 1);
        end
        if (dup_any)      w_repl_idx = dup_idx;
        else if (inv_any) w_repl_idx = inv_idx;
        else              w_repl_idx = IDX_W'(node - (TLB_ENTRIES - 1));
    end

    assign bus.port_io_replace_en = {{(TLB_ENTRIES-1){1'b0}}, 1'b1} << w_repl_idx;
    assign bus.port_io_plru_q     = r_plru;

    // Hit touch first, then the update touch so the written entry wins
    always_comb begin
        w_plru_next = r_plru;
        if (w_lu_hit) w_plru_next = plru_touch(w_plru_next, w_hit_idx);
        if (w_commit) w_plru_next = plru_touch(w_plru_next, w_repl_idx);
    end

    // Entry array and PLRU state; flush beats a same-cycle update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                r_valid[i]   <= 1'b0;
                r_is_4m[i]   <= 1'b0;
                r_vpn1[i]    <= '0;
                r_vpn0[i]    <= '0;
                r_asid[i]    <= '0;
                r_content[i] <= '0;
            end
            r_plru <= '0;
        end else begin
            if (bus.flush_i) begin
                for (int i = 0; i < TLB_ENTRIES; i++) begin
                    if (w_fl_hit[i]) r_valid[i] <= 1'b0;
                end
            end else if (bus.update_valid_i) begin
                r_valid[w_repl_idx]   <= 1'b1;
                r_is_4m[w_repl_idx]   <= bus.update_is_4M_i;
                r_vpn1[w_repl_idx]    <= bus.update_vpn_i[19:10];
                r_vpn0[w_repl_idx]    <= bus.update_vpn_i[9:0];
                r_asid[w_repl_idx]    <= bus.update_asid_i;
                r_content[w_repl_idx] <= bus.update_content_i;
            end
            r_plru <= w_plru_next;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cva6_tlb_plru_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_cva6_tlb_plru_model
// Brief    : Directed self-checking bench for cva6_tlb_plru_model
//            (TLB_ENTRIES=4, ASID_WIDTH=1). Inputs change on the falling
//            edge; outputs are compared shortly after.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cva6_tlb_plru_model;
    localparam int TLB_ENTRIES = 4;
    localparam int ASID_WIDTH  = 1;
    localparam int TAG_W       = 22 + ASID_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cva6_tlb_plru_model_if #(.TLB_ENTRIES(TLB_ENTRIES), .ASID_WIDTH(ASID_WIDTH)) bus ();

    cva6_tlb_plru_model #(.TLB_ENTRIES(TLB_ENTRIES), .ASID_WIDTH(ASID_WIDTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.flush_i               = 1'b0;
        bus.asid_to_be_flushed_i  = '0;
        bus.vaddr_to_be_flushed_i = '0;
        bus.update_valid_i        = 1'b0;
        bus.update_is_4M_i        = 1'b0;
        bus.update_vpn_i          = '0;
        bus.update_asid_i         = '0;
        bus.update_content_i      = '0;
        bus.lu_access_i           = 1'b0;
        bus.lu_asid_i             = '0;
        bus.lu_vaddr_i            = '0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic drive_update(input logic is4m, input logic [19:0] vpn,
                                input logic asid, input logic [31:0] pte);
        bus.update_valid_i   = 1'b1;
        bus.update_is_4M_i   = is4m;
        bus.update_vpn_i     = vpn;
        bus.update_asid_i    = asid;
        bus.update_content_i = pte;
    endtask

    task automatic drive_lookup(input logic [31:0] va, input logic asid);
        bus.lu_access_i = 1'b1;
        bus.lu_vaddr_i  = va;
        bus.lu_asid_i   = asid;
    endtask

    task automatic drive_flush(input logic asid, input logic [31:0] va);
        bus.flush_i               = 1'b1;
        bus.asid_to_be_flushed_i  = asid;
        bus.vaddr_to_be_flushed_i = va;
    endtask

    function automatic logic [3:0] valid_vec();
        logic [3:0] v;
        for (int i = 0; i < TLB_ENTRIES; i++) v[i] = bus.port_io_tags_q[i*TAG_W + TAG_W - 1];
        return v;
    endfunction

    task automatic chk_lookup(input string tag, input logic hit, input logic [31:0] pte, input logic is4m);
        chk({tag, "_hit"},     64'(bus.lu_hit_o),     64'(hit));
        chk({tag, "_content"}, 64'(bus.lu_content_o), 64'(pte));
        chk({tag, "_is4m"},    64'(bus.lu_is_4M_o),   64'(is4m));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp4;
        idle();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        drive_lookup(32'h0000_1000, 1'b0);
        #1;
        chk_lookup("reset", 1'b0, 32'd0, 1'b0);
        chk("reset_repl", 64'(bus.port_io_replace_en), 64'(4'b0001));
        chk("reset_plru", 64'(bus.port_io_plru_q), 64'(3'b000));
        chk("reset_tags", 64'(bus.port_io_tags_q), 64'd0);
        rst_n = 1'b1;
        idle();

        // Fill four entries: invalid-first allocation in index order
        for (int k = 0; k < 4; k++) begin
            step();
            drive_update(1'b0, 20'(k + 1), 1'b0, 32'h0000_100F + 32'(k) * 32'h1000);
            #1;
            exp4 = 4'b0001 << k;
            chk($sformatf("fill%0d_repl", k), 64'(bus.port_io_replace_en), 64'(exp4));
        end
        step(); #1;
        chk("fill_plru", 64'(bus.port_io_plru_q), 64'(3'b000));
        chk("fill_repl", 64'(bus.port_io_replace_en), 64'(4'b0001));
        chk("fill_tag0", 64'(bus.port_io_tags_q[0 +: TAG_W]), 64'(23'h40_0002));
        chk("fill_content1", 64'(bus.port_io_content_q[32 +: 32]), 64'(32'h0000_200F));

        // Hit on entry 0 moves the victim to entry 2
        step(); drive_lookup(32'h0000_1ABC, 1'b0); #1;
        chk_lookup("hit0", 1'b1, 32'h0000_100F, 1'b0);
        step(); #1;
        chk("hit0_plru", 64'(bus.port_io_plru_q), 64'(3'b011));
        chk("hit0_repl", 64'(bus.port_io_replace_en), 64'(4'b0100));
        drive_update(1'b0, 20'h00005, 1'b0, 32'h0000_500F); #1;
        chk("upd5_repl", 64'(bus.port_io_replace_en), 64'(4'b0100));
        step(); #1;
        chk("upd5_plru", 64'(bus.port_io_plru_q), 64'(3'b110));
        chk("upd5_repl_next", 64'(bus.port_io_replace_en), 64'(4'b0010));
        chk("upd5_content2", 64'(bus.port_io_content_q[64 +: 32]), 64'(32'h0000_500F));

        // Duplicate tag overwrites its entry rather than the PLRU victim
        drive_update(1'b0, 20'h00005, 1'b0, 32'h0000_01CF); #1;
        chk("dup_repl", 64'(bus.port_io_replace_en), 64'(4'b0100));
        step(); drive_lookup(32'h0000_5000, 1'b0); #1;
        chk_lookup("dup", 1'b1, 32'h0000_01CF, 1'b0);
        chk("dup_plru", 64'(bus.port_io_plru_q), 64'(3'b110));
        step(); drive_lookup(32'h0000_3ABC, 1'b0); #1;
        chk_lookup("evicted", 1'b0, 32'd0, 1'b0);

        // Megapages: global entry hits any ASID, non-global does not
        step(); drive_update(1'b1, 20'h40000, 1'b0, 32'h1234_502F); #1;
        chk("mega_repl", 64'(bus.port_io_replace_en), 64'(4'b0010));
        step(); drive_lookup(32'h4012_3456, 1'b1); #1;
        chk_lookup("mega_g", 1'b1, 32'h1234_502F, 1'b1);
        step(); drive_update(1'b1, 20'h40400, 1'b0, 32'h0000_700F); #1;
        chk("mega2_repl", 64'(bus.port_io_replace_en), 64'(4'b1000));
        step(); drive_lookup(32'h4042_3456, 1'b1); #1;
        chk_lookup("mega_asid_miss", 1'b0, 32'd0, 1'b0);
        drive_lookup(32'h4042_3456, 1'b0); #1;
        chk_lookup("mega_asid_hit", 1'b1, 32'h0000_700F, 1'b1);
        bus.lu_access_i = 1'b0;

        // Flush everything; PLRU must be left alone
        drive_flush(1'b0, 32'd0);
        step(); #1;
        chk("flushall1_valid", 64'(valid_vec()), 64'(4'b0000));
        chk("flushall1_plru", 64'(bus.port_io_plru_q), 64'(3'b000));
        chk("flushall1_repl", 64'(bus.port_io_replace_en), 64'(4'b0001));

        // Selective flushes by ASID and by vaddr
        drive_update(1'b0, 20'h00010, 1'b1, 32'h0001_000F);
        step(); drive_update(1'b0, 20'h00011, 1'b1, 32'h0001_102F);
        step(); drive_update(1'b0, 20'h00012, 1'b0, 32'h0001_200F);
        step(); drive_flush(1'b1, 32'd0);
        step(); #1;
        chk("flush_asid_valid", 64'(valid_vec()), 64'(4'b0110));
        chk("flush_asid_repl", 64'(bus.port_io_replace_en), 64'(4'b0001));
        chk("flush_asid_plru", 64'(bus.port_io_plru_q), 64'(3'b100));
        drive_flush(1'b0, 32'h0001_2345);
        step(); #1;
        chk("flush_va_valid", 64'(valid_vec()), 64'(4'b0010));
        drive_flush(1'b0, 32'd0);
        step(); #1;
        chk("flushall2_valid", 64'(valid_vec()), 64'(4'b0000));
        chk("flushall2_repl", 64'(bus.port_io_replace_en), 64'(4'b0001));

        // Flush and update together: the update is dropped
        drive_update(1'b0, 20'h00020, 1'b0, 32'hDEAD_BE0F);
        drive_flush(1'b0, 32'd0);
        step(); #1;
        chk("flush_upd_valid", 64'(valid_vec()), 64'(4'b0000));
        chk("flush_upd_content0", 64'(bus.port_io_content_q[0 +: 32]), 64'(32'h0001_000F));
        chk("flush_upd_plru", 64'(bus.port_io_plru_q), 64'(3'b100));

        // Asynchronous reset in the middle of a cycle
        drive_update(1'b0, 20'h00030, 1'b0, 32'h3000_000F);
        step(); drive_lookup(32'h0003_0000, 1'b0); #1;
        chk_lookup("pre_rst", 1'b1, 32'h3000_000F, 1'b0);
        chk("pre_rst_plru", 64'(bus.port_io_plru_q), 64'(3'b111));
        drive_update(1'b0, 20'h00031, 1'b0, 32'h3100_000F);
        rst_n = 1'b0;
        #1;
        chk_lookup("mid_rst", 1'b0, 32'd0, 1'b0);
        chk("mid_rst_repl", 64'(bus.port_io_replace_en), 64'(4'b0001));
        chk("mid_rst_plru", 64'(bus.port_io_plru_q), 64'(3'b000));
        chk("mid_rst_tags", 64'(bus.port_io_tags_q), 64'd0);
        @(posedge clk); #1;
        chk("rst_hold_tags", 64'(bus.port_io_tags_q), 64'd0);
        step(); rst_n = 1'b1; #1;
        chk("post_rst_tags", 64'(bus.port_io_tags_q), 64'd0);
        chk("post_rst_content", 64'(bus.port_io_content_q), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
